apb_slv_memory_block: RTL and testbench

APB_SLV_MEMORY_BLOCK -- requirements
Module: apb_slv_memory

---
 rtl/apb_slv_memory_block.sv | 89 ++++++++
 tb/tb_apb_slv_memory_block.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_slv_memory_block.sv
// rtl/apb_slv_memory_block.sv - APB slave word memory with byte strobes; optional PSLVERR via APB_SLV_MEMORY_SLVERR_EN
module apb_slv_memory_block #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 5
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [ADDR_SIZE-1:0]   PADDR,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [DATA_SIZE-1:0]   PWDATA,
    input  logic [DATA_SIZE/8-1:0] PSTROBE,
    output logic                   PREADY,
    output logic [DATA_SIZE-1:0]   PRDATA,
    output logic                   PSLVERR
);
    localparam int NBYTES = DATA_SIZE / 8;
    localparam int DEPTH  = 2 ** ADDR_SIZE;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   mem_q [DEPTH];
    logic [DATA_SIZE-1:0]   prdata_q;
    logic                   access;
    logic                   wr_en;
    logic                   rd_sample;
    logic                   err;

    // PRESETn is active-high despite its name
    assign access    = PSEL & PENABLE;
    assign rd_sample = PSEL & ~PENABLE & ~PWRITE;

`ifdef APB_SLV_MEMORY_SLVERR_EN
    assign err     = access & ((state_q != SETUP) | (PWRITE & ~|PSTROBE));
    assign PSLVERR = err & ~PRESETn;
    assign PRDATA  = err ? '0 : prdata_q;
`else
    assign err     = 1'b0;
    assign PSLVERR = 1'b0;
    assign PRDATA  = prdata_q;
`endif

    assign wr_en  = access & PWRITE & ~err;
    assign PREADY = access & ~PRESETn;

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    if (PSEL && !PENABLE) state_d = SETUP;
            SETUP:   if (PSEL && PENABLE)  state_d = ACCESS;
            ACCESS:  if (PSEL && !PENABLE) state_d = SETUP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A write in the access phase lands before the next setup-phase sample,
    // so read-after-write to the same word returns the new data.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (PSTROBE[b]) begin
                    mem_q[PADDR][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            prdata_q <= '0;
        end else if (rd_sample) begin
            prdata_q <= mem_q[PADDR];
        end
    end
endmodule

// File: tb/tb_apb_slv_memory_block.sv
// tb/tb_apb_slv_memory_block.sv - scoreboard testbench for apb_slv_memory_block
module tb_apb_slv_memory_block;
    logic        PCLK;
    logic        PRESETn;
    logic [4:0]  PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTROBE;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    typedef struct {
        bit          is_wr;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    apb_slv_memory_block #(.DATA_SIZE(32), .ADDR_SIZE(5)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PSTROBE (PSTROBE),
        .PREADY  (PREADY),
        .PRDATA  (PRDATA),
        .PSLVERR (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        #2;
        forever #5 PCLK = ~PCLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit strobe_err(input logic [3:0] strb);
`ifdef APB_SLV_MEMORY_SLVERR_EN
        return (strb == 4'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic apb_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        exp_t e;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = addr; PWDATA = data; PSTROBE = strb;
        @(posedge PCLK); #1;
        e.is_wr = 1'b1; e.err = strobe_err(strb); e.data = '0;
        sb.push_back(e);
        PENABLE = 1'b1;
    endtask

    task automatic apb_read(input logic [4:0] addr, input logic [31:0] exp_data);
        exp_t e;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = addr; PWDATA = 32'h0BAD_0BAD; PSTROBE = 4'hA;
        @(posedge PCLK); #1;
        e.is_wr = 1'b0; e.err = 1'b0; e.data = exp_data;
        sb.push_back(e);
        PENABLE = 1'b1;
    endtask

    task automatic apb_idle();
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    always @(negedge PCLK) begin
        if (PRESETn) begin
            check("rst_pready", 32'(PREADY), 32'h0);
            check("rst_prdata", PRDATA, 32'h0);
            check("rst_pslverr", 32'(PSLVERR), 32'h0);
        end else if (PSEL && PENABLE) begin
            check("pready_access", 32'(PREADY), 32'h1);
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got access phase expected none at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("pslverr_access", 32'(PSLVERR), 32'(mon_e.err));
                if (!mon_e.is_wr) check("prdata", PRDATA, mon_e.data);
            end
        end else begin
            check("pready_idle", 32'(PREADY), 32'h0);
            check("pslverr_idle", 32'(PSLVERR), 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cnt;
        exp_t e;
        PRESETn = 1'b1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR = 5'h00; PWDATA = 32'hFFFF_FFFF; PSTROBE = 4'hF;
        #3;
        check("reset_pready", 32'(PREADY), 32'h0);
        check("reset_prdata", PRDATA, 32'h0);
        check("reset_pslverr", 32'(PSLVERR), 32'h0);
        #7;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;

        apb_read(5'h1F, 32'h0000_0000);
        apb_idle();

        apb_write(5'h03, 32'hDEAD_BEEF, 4'hF);
        apb_idle();
        apb_read(5'h03, 32'hDEAD_BEEF);
        apb_idle();

        apb_write(5'h03, 32'h1122_3344, 4'b0101);
        apb_idle();
        apb_read(5'h03, 32'hDE22_BE44);
        apb_idle();

        apb_write(5'h00, 32'hA5A5_0001, 4'hF);
        apb_write(5'h1F, 32'h5A5A_FFFE, 4'hF);
        apb_read(5'h00, 32'hA5A5_0001);
        apb_read(5'h1F, 32'h5A5A_FFFE);
        apb_read(5'h03, 32'hDE22_BE44);
        apb_idle();

        apb_write(5'h07, 32'hCAFE_F00D, 4'b1100);
        apb_read(5'h07, 32'hCAFE_0000);
        apb_idle();

        PSEL = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1;
        PADDR = 5'h00; PWDATA = 32'hFFFF_FFFF; PSTROBE = 4'hF;
        #730;
        PENABLE = 1'b0;
        #325;
        PENABLE = 1'b1;
        #40;
        PENABLE = 1'b0;
        apb_read(5'h00, 32'hA5A5_0001);
        apb_read(5'h1F, 32'h5A5A_FFFE);
        apb_idle();

        apb_write(5'h05, 32'h1234_5678, 4'h0);
        apb_idle();
        apb_read(5'h05, 32'h0000_0000);
        apb_idle();

`ifdef APB_SLV_MEMORY_SLVERR_EN
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 5'h03;
        e.is_wr = 1'b0; e.err = 1'b1; e.data = 32'h0;
        sb.push_back(e);
        apb_idle();
`endif

        apb_write(5'h09, 32'hFFFF_FFFF, 4'hF);
        @(negedge PCLK); #1;
        PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #3;
        PRESETn = 1'b0;
        #1;
        check("midrst_prdata", PRDATA, 32'h0);
        check("midrst_pready", 32'(PREADY), 32'h0);
        apb_read(5'h09, 32'h0000_0000);
        apb_read(5'h03, 32'h0000_0000);
        apb_idle();

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(posedge PCLK);
            wait_cnt++;
        end
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
